// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage core: RAW stalls, branch flushes,
// data-memory wait-state freezes and saturating stall/flush event counters.
module pipe_hazard_ctrl #(
  parameter int MEM_WAIT = 4,
  parameter int FWD_EN   = 0,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       src1,
  input  logic [3:0]       src2,
  input  logic             twoSrc,
  input  logic [3:0]       exDest,
  input  logic             exWbEn,
  input  logic             exMemRead,
  input  logic [3:0]       memDest,
  input  logic             memWbEn,
  input  logic             memAccess,
  input  logic             branchTaken,
  input  logic             cntClr,
  output logic             hazard,
  output logic             freezePc,
  output logic             freezeIfId,
  output logic             flushIfId,
  output logic             flushIdEx,
  output logic             freezeAll,
  output logic [CNT_W-1:0] stallCnt,
  output logic [CNT_W-1:0] flushCnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  localparam bit         HAS_WAIT = (MEM_WAIT > 1);
  localparam logic [3:0] WAIT_LD  = 4'(MEM_WAIT - 2);

  state_t     state;
  logic [3:0] wait_cnt;
  logic       ex_hit;
  logic       mem_hit;
  logic       raw_haz;
  logic       mem_freeze;

  // A 2-cycle latency needs only the single IDLE freeze cycle, so it skips WAIT;
  // otherwise WAIT lasts exactly WAIT_LD cycles, for MEM_WAIT-1 frozen cycles in all.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (memAccess && HAS_WAIT) begin
            wait_cnt <= WAIT_LD;
            state    <= (WAIT_LD == 4'd0) ? S_DONE : S_WAIT;
          end
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt <= 4'd1) state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign ex_hit  = exWbEn  & ((src1 == exDest)  | (twoSrc & (src2 == exDest)));
  assign mem_hit = memWbEn & ((src1 == memDest) | (twoSrc & (src2 == memDest)));
  assign raw_haz = (FWD_EN != 0) ? (ex_hit & exMemRead) : (ex_hit | mem_hit);

  assign mem_freeze = (state == S_WAIT) |
                      ((state == S_IDLE) & memAccess & HAS_WAIT);

  // Gated by rst so every control reads 0 while reset is held, even with an access pending.
  always_comb begin
    hazard     = 1'b0;
    freezePc   = 1'b0;
    freezeIfId = 1'b0;
    flushIfId  = 1'b0;
    flushIdEx  = 1'b0;
    freezeAll  = 1'b0;
    if (rst) begin
      if (mem_freeze) begin
        freezeAll = 1'b1;
      end else if (branchTaken) begin
        flushIfId = 1'b1;
        flushIdEx = 1'b1;
      end else if (raw_haz) begin
        hazard     = 1'b1;
        freezePc   = 1'b1;
        freezeIfId = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stallCnt <= '0;
      flushCnt <= '0;
    end else if (cntClr) begin
      stallCnt <= '0;
      flushCnt <= '0;
    end else begin
      if (freezePc && (stallCnt != '1)) stallCnt <= stallCnt + 1'b1;
      if (flushIfId && (flushCnt != '1)) flushCnt <= flushCnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: three instances (no forwarding, forwarding,
// single-cycle memory) share one stimulus bus and are checked against hand values.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  src1, src2, exDest, memDest;
  logic        twoSrc, exWbEn, exMemRead, memWbEn, memAccess, branchTaken, cntClr;

  logic        hazard[3], freezePc[3], freezeIfId[3], flushIfId[3], flushIdEx[3], freezeAll[3];
  logic [15:0] stallCnt[3], flushCnt[3];

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MEM_WAIT(4), .FWD_EN(0), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .src1(src1), .src2(src2), .twoSrc(twoSrc),
    .exDest(exDest), .exWbEn(exWbEn), .exMemRead(exMemRead),
    .memDest(memDest), .memWbEn(memWbEn), .memAccess(memAccess),
    .branchTaken(branchTaken), .cntClr(cntClr),
    .hazard(hazard[0]), .freezePc(freezePc[0]), .freezeIfId(freezeIfId[0]),
    .flushIfId(flushIfId[0]), .flushIdEx(flushIdEx[0]), .freezeAll(freezeAll[0]),
    .stallCnt(stallCnt[0]), .flushCnt(flushCnt[0]));

  pipe_hazard_ctrl #(.MEM_WAIT(4), .FWD_EN(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .src1(src1), .src2(src2), .twoSrc(twoSrc),
    .exDest(exDest), .exWbEn(exWbEn), .exMemRead(exMemRead),
    .memDest(memDest), .memWbEn(memWbEn), .memAccess(memAccess),
    .branchTaken(branchTaken), .cntClr(cntClr),
    .hazard(hazard[1]), .freezePc(freezePc[1]), .freezeIfId(freezeIfId[1]),
    .flushIfId(flushIfId[1]), .flushIdEx(flushIdEx[1]), .freezeAll(freezeAll[1]),
    .stallCnt(stallCnt[1]), .flushCnt(flushCnt[1]));

  pipe_hazard_ctrl #(.MEM_WAIT(1), .FWD_EN(0), .CNT_W(16)) dut2 (
    .clk(clk), .rst(rst), .src1(src1), .src2(src2), .twoSrc(twoSrc),
    .exDest(exDest), .exWbEn(exWbEn), .exMemRead(exMemRead),
    .memDest(memDest), .memWbEn(memWbEn), .memAccess(memAccess),
    .branchTaken(branchTaken), .cntClr(cntClr),
    .hazard(hazard[2]), .freezePc(freezePc[2]), .freezeIfId(freezeIfId[2]),
    .flushIfId(flushIfId[2]), .flushIdEx(flushIdEx[2]), .freezeAll(freezeAll[2]),
    .stallCnt(stallCnt[2]), .flushCnt(flushCnt[2]));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    src1 = 4'd0; src2 = 4'd0; exDest = 4'd0; memDest = 4'd0;
    twoSrc = 1'b0; exWbEn = 1'b0; exMemRead = 1'b0; memWbEn = 1'b0;
    memAccess = 1'b0; branchTaken = 1'b0; cntClr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    clear_inputs();
    memAccess = 1'b1;
    #2;
    n_checks++;
    if (freezeAll[0] !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_freeze_held: got %0b want 0", freezeAll[0]); end
    n_checks++;
    if (stallCnt[0] !== 16'd0 || flushCnt[0] !== 16'd0) begin
      n_fails++; $display("[TB] FAIL reset_cnt: got %0h/%0h want 0/0", stallCnt[0], flushCnt[0]);
    end
    tick();
    rst = 1'b1;
    #1;
    n_checks++;
    if (freezeAll[0] !== 1'b1) begin n_fails++; $display("[TB] FAIL idle_access_freeze: got %0b want 1", freezeAll[0]); end
    tick();
    tick();
    n_checks++;
    if (freezeAll[0] !== 1'b1) begin n_fails++; $display("[TB] FAIL mid_wait_freeze: got %0b want 1", freezeAll[0]); end
    rst = 1'b0;
    #1;
    n_checks++;
    if (freezeAll[0] !== 1'b0) begin n_fails++; $display("[TB] FAIL async_reset_freeze: got %0b want 0", freezeAll[0]); end
    memAccess = 1'b0;
    rst = 1'b1;
    #1;
    n_checks++;
    if (freezeAll[0] !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_state_idle: got %0b want 0", freezeAll[0]); end
    n_checks++;
    if (stallCnt[0] !== 16'd0 || flushCnt[0] !== 16'd0) begin
      n_fails++; $display("[TB] FAIL post_reset_cnt: got %0h/%0h want 0/0", stallCnt[0], flushCnt[0]);
    end
  endtask

  task automatic test_raw();
    tick();
    exDest = 4'd3; exWbEn = 1'b1; src1 = 4'd3;
    #1;
    n_checks++;
    if ({hazard[0], freezePc[0], freezeIfId[0], flushIfId[0], flushIdEx[0]} !== 5'b11100) begin
      n_fails++; $display("[TB] FAIL raw_ex_fwd0: got %05b want 11100",
        {hazard[0], freezePc[0], freezeIfId[0], flushIfId[0], flushIdEx[0]});
    end
    n_checks++;
    if (hazard[1] !== 1'b0) begin n_fails++; $display("[TB] FAIL raw_ex_fwd1: got %0b want 0", hazard[1]); end
    n_checks++;
    if (stallCnt[0] !== 16'd0) begin n_fails++; $display("[TB] FAIL stall_before: got %0h want 0", stallCnt[0]); end
    tick();
    clear_inputs();
    n_checks++;
    if (stallCnt[0] !== 16'd1 || stallCnt[1] !== 16'd0) begin
      n_fails++; $display("[TB] FAIL stall_after: got %0h/%0h want 1/0", stallCnt[0], stallCnt[1]);
    end
  endtask

  task automatic test_two_src();
    src2 = 4'd5; memDest = 4'd5; memWbEn = 1'b1; src1 = 4'd0; twoSrc = 1'b0;
    #1;
    n_checks++;
    if (hazard[0] !== 1'b0) begin n_fails++; $display("[TB] FAIL twosrc0: got %0b want 0", hazard[0]); end
    twoSrc = 1'b1;
    #1;
    n_checks++;
    if (hazard[0] !== 1'b1) begin n_fails++; $display("[TB] FAIL twosrc1_fwd0: got %0b want 1", hazard[0]); end
    n_checks++;
    if (hazard[1] !== 1'b0) begin n_fails++; $display("[TB] FAIL twosrc1_fwd1: got %0b want 0", hazard[1]); end
    clear_inputs();
  endtask

  task automatic test_load_use();
    tick();
    exMemRead = 1'b1; exWbEn = 1'b1; exDest = 4'd2; src2 = 4'd2; twoSrc = 1'b1; src1 = 4'd7;
    #1;
    n_checks++;
    if (hazard[1] !== 1'b1) begin n_fails++; $display("[TB] FAIL load_use: got %0b want 1", hazard[1]); end
    exMemRead = 1'b0;
    #1;
    n_checks++;
    if (hazard[1] !== 1'b0) begin n_fails++; $display("[TB] FAIL non_load_fwd1: got %0b want 0", hazard[1]); end
    n_checks++;
    if (hazard[0] !== 1'b1) begin n_fails++; $display("[TB] FAIL non_load_fwd0: got %0b want 1", hazard[0]); end
    clear_inputs();
  endtask

  task automatic test_mem_wait();
    tick();
    memAccess = 1'b1; branchTaken = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++;
      if ({freezeAll[0], flushIfId[0], flushIdEx[0], hazard[0]} !== 4'b1000) begin
        n_fails++; $display("[TB] FAIL wait_cycle%0d: got %04b want 1000", c,
          {freezeAll[0], flushIfId[0], flushIdEx[0], hazard[0]});
      end
      tick();
    end
    #1;
    n_checks++;
    if ({freezeAll[0], flushIfId[0], flushIdEx[0]} !== 3'b011) begin
      n_fails++; $display("[TB] FAIL done_cycle: got %03b want 011", {freezeAll[0], flushIfId[0], flushIdEx[0]});
    end
    n_checks++;
    if (freezeAll[2] !== 1'b0 || flushIfId[2] !== 1'b1) begin
      n_fails++; $display("[TB] FAIL memwait1: got freeze %0b flush %0b want 0 1", freezeAll[2], flushIfId[2]);
    end
    tick();
    clear_inputs();
    #1;
    n_checks++;
    if (freezeAll[0] !== 1'b0) begin n_fails++; $display("[TB] FAIL after_done: got %0b want 0", freezeAll[0]); end
    n_checks++;
    if (flushCnt[0] !== 16'd1 || flushCnt[2] !== 16'd4 || stallCnt[0] !== 16'd1) begin
      n_fails++; $display("[TB] FAIL mem_counts: got %0h/%0h/%0h want 1/4/1", flushCnt[0], flushCnt[2], stallCnt[0]);
    end
  endtask

  task automatic test_branch_vs_raw();
    tick();
    exDest = 4'd3; exWbEn = 1'b1; src1 = 4'd3; branchTaken = 1'b1;
    #1;
    n_checks++;
    if ({hazard[0], freezePc[0], freezeIfId[0], flushIfId[0], flushIdEx[0]} !== 5'b00011) begin
      n_fails++; $display("[TB] FAIL branch_over_raw: got %05b want 00011",
        {hazard[0], freezePc[0], freezeIfId[0], flushIfId[0], flushIdEx[0]});
    end
    tick();
    clear_inputs();
    n_checks++;
    if (flushCnt[0] !== 16'd2 || stallCnt[0] !== 16'd1) begin
      n_fails++; $display("[TB] FAIL branch_counts: got %0h/%0h want 2/1", flushCnt[0], stallCnt[0]);
    end
  endtask

  task automatic test_saturation();
    branchTaken = 1'b1;
    for (int c = 0; c < 65540; c++) tick();
    n_checks++;
    if (flushCnt[0] !== 16'hFFFF) begin n_fails++; $display("[TB] FAIL flush_sat: got %0h want ffff", flushCnt[0]); end
    tick();
    n_checks++;
    if (flushCnt[0] !== 16'hFFFF) begin n_fails++; $display("[TB] FAIL flush_no_wrap: got %0h want ffff", flushCnt[0]); end
    cntClr = 1'b1;
    tick();
    cntClr = 1'b0;
    n_checks++;
    if (flushCnt[0] !== 16'd0 || stallCnt[0] !== 16'd0) begin
      n_fails++; $display("[TB] FAIL clr_wins: got %0h/%0h want 0/0", flushCnt[0], stallCnt[0]);
    end
    tick();
    clear_inputs();
    n_checks++;
    if (flushCnt[0] !== 16'd1) begin n_fails++; $display("[TB] FAIL count_resume: got %0h want 1", flushCnt[0]); end
  endtask

  initial begin
    test_reset();
    test_raw();
    test_two_src();
    test_load_use();
    test_mem_wait();
    test_branch_vs_raw();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
